// File: rtl/compress_pkg.sv
// Definitions shared by compress_unit and decompress_unit: token tags, decoder
// states and default field widths.
package compress_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int RUN_W_DEF   = 16;
    localparam int DELTA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_NONE  = 2'b00,
        ST_LIT   = 2'b01,
        ST_RUN   = 2'b10,
        ST_DELTA = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DELTA = 2'b10
    } state_t;

endpackage

// File: rtl/delta_lane_sel.sv
// Picks one signed delta lane out of a DELTA payload, sign-extends it and adds
// it to the reference word (modulo 2^WIDTH).
module delta_lane_sel #(
    parameter int WIDTH   = 32,
    parameter int DELTA_W = 8,
    parameter int LANES   = WIDTH / DELTA_W,
    parameter int SEL_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [WIDTH-1:0] payload,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] sum
);

    logic [LANES-1:0][DELTA_W-1:0] lanes;
    logic [DELTA_W-1:0]            d;

    assign lanes = payload;
    assign d     = lanes[sel];
    assign sum   = base + {{(WIDTH-DELTA_W){d[DELTA_W-1]}}, d};

endmodule

// File: rtl/decompress_unit.sv
// Streaming decoder: expands LIT/RUN/DELTA tokens into raw words through a
// single-entry valid/ready output register.
module decompress_unit
    import compress_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int RUN_W   = RUN_W_DEF,
    parameter int DELTA_W = DELTA_W_DEF,
    parameter int LANES   = WIDTH / DELTA_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       status_in,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             no_ref
);

    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t             state;
    logic [WIDTH-1:0]   last;
    logic [WIDTH-1:0]   payload;
    logic [RUN_W-1:0]   cnt;
    logic [SEL_W-1:0]   lane;
    logic               seen_lit;

    logic               slot_free;
    logic [RUN_W-1:0]   run_n;
    logic               idle;
    logic [WIDTH-1:0]   sel_word;
    logic [SEL_W-1:0]   sel_idx;
    logic [WIDTH-1:0]   delta_sum;

    assign slot_free = !out_valid || out_ready;
    assign idle      = (state == S_IDLE);
    assign in_ready  = enable && idle && slot_free;
    assign run_n     = data_in[RUN_W-1:0];

    // Lane 0 comes straight from the input at accept; later lanes from the held payload.
    assign sel_word = idle ? data_in : payload;
    assign sel_idx  = idle ? '0 : lane;

    delta_lane_sel #(
        .WIDTH   (WIDTH),
        .DELTA_W (DELTA_W),
        .LANES   (LANES),
        .SEL_W   (SEL_W)
    ) u_lane_sel (
        .payload (sel_word),
        .sel     (sel_idx),
        .base    (last),
        .sum     (delta_sum)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            data_out  <= '0;
            out_valid <= 1'b0;
            no_ref    <= 1'b0;
            last      <= '0;
            payload   <= '0;
            cnt       <= '0;
            lane      <= '0;
            seen_lit  <= 1'b0;
        end else if (enable && slot_free) begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    case (status_t'(status_in))
                        ST_LIT: begin
                            data_out  <= data_in;
                            last      <= data_in;
                            seen_lit  <= 1'b1;
                            out_valid <= 1'b1;
                        end
                        ST_RUN: begin
                            if (!seen_lit) no_ref <= 1'b1;
                            if (run_n != '0) begin
                                data_out  <= last;
                                out_valid <= 1'b1;
                                cnt       <= run_n - RUN_W'(1);
                                if (run_n != RUN_W'(1)) state <= S_RUN;
                            end
                        end
                        ST_DELTA: begin
                            if (!seen_lit) no_ref <= 1'b1;
                            data_out  <= delta_sum;
                            last      <= delta_sum;
                            out_valid <= 1'b1;
                            payload   <= data_in;
                            lane      <= SEL_W'(1);
                            state     <= S_DELTA;
                        end
                        default: ;
                    endcase
                end
                S_RUN: begin
                    data_out  <= last;
                    out_valid <= 1'b1;
                    cnt       <= cnt - RUN_W'(1);
                    if (cnt == RUN_W'(1)) state <= S_IDLE;
                end
                S_DELTA: begin
                    data_out  <= delta_sum;
                    last      <= delta_sum;
                    out_valid <= 1'b1;
                    if (lane == SEL_W'(LANES - 1)) begin
                        lane  <= '0;
                        state <= S_IDLE;
                    end else begin
                        lane <= lane + SEL_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decompress_unit.sv
// Bench for decompress_unit: directed token sequences plus random traffic,
// compared cycle by cycle against a word-queue reference model.
module tb_decompress_unit;
    import compress_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [31:0] data_in;
    logic [1:0]  status_in;
    logic        in_ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        no_ref;

    always #5 clk = ~clk;

    decompress_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .data_in   (data_in),
        .status_in (status_in),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .no_ref    (no_ref)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: words owed to the consumer but not yet in the output register.
    logic [31:0] mq[$];
    logic        m_full;
    logic [31:0] m_reg;
    logic [31:0] m_last;
    logic        m_seen;
    logic        m_noref;
    logic [31:0] log_q[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_in_ready(logic en, logic ordy);
        return en && (mq.size() == 0) && (!m_full || ordy);
    endfunction

    task automatic model_reset();
        mq.delete();
        log_q.delete();
        m_full = 0; m_reg = 0; m_last = 0; m_seen = 0; m_noref = 0;
    endtask

    task automatic expand(logic [1:0] st, logic [31:0] d);
        case (st)
            ST_LIT: begin
                mq.push_back(d);
                m_last = d;
                m_seen = 1;
            end
            ST_RUN: begin
                if (!m_seen) m_noref = 1;
                for (int i = 0; i < int'(d[15:0]); i++) mq.push_back(m_last);
            end
            ST_DELTA: begin
                if (!m_seen) m_noref = 1;
                for (int k = 0; k < 4; k++) begin
                    logic [7:0] b;
                    b = d[8*k +: 8];
                    m_last = m_last + {{24{b[7]}}, b};
                    mq.push_back(m_last);
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(logic en, logic [1:0] st, logic [31:0] d, logic ordy);
        logic acc;
        @(negedge clk);
        enable = en; status_in = st; data_in = d; out_ready = ordy;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        chk("data_out", data_out, m_reg);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready(en, ordy)});
        chk("no_ref", {31'd0, no_ref}, {31'd0, m_noref});
        acc = m_in_ready(en, ordy) && (st != ST_NONE);
        @(posedge clk);
        if (en && (!m_full || ordy)) begin
            if (m_full && ordy) log_q.push_back(m_reg);
            if (acc) expand(st, d);
            if (mq.size() > 0) begin
                m_reg  = mq.pop_front();
                m_full = 1;
            end else begin
                m_full = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0; status_in = ST_NONE; enable = 1; out_ready = 1;
        model_reset();
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_no_ref", {31'd0, no_ref}, 32'd0);
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_full || mq.size() > 0); i++)
            step(1, ST_NONE, 32'd0, 1);
        step(1, ST_NONE, 32'd0, 1);
    endtask

    task automatic chk_log(string tag, input logic [31:0] e[$]);
        chk({tag, "_len"}, log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk(tag, log_q[i], e[i]);
        log_q.delete();
    endtask

    initial begin
        logic [31:0] e[$];
        logic [31:0] r;
        logic [1:0]  st;
        resetn = 0; enable = 0; data_in = 0; status_in = ST_NONE; out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // back-to-back literals
        step(1, ST_LIT, 32'd2, 1);
        step(1, ST_LIT, 32'd101, 1);
        step(1, ST_LIT, 32'd1001, 1);
        drain();
        e = '{32'd2, 32'd101, 32'd1001};
        chk_log("lit3", e);

        // run of 3 after a literal
        step(1, ST_LIT, 32'd101, 1);
        step(1, ST_RUN, 32'd3, 1);
        drain();
        e = '{32'd101, 32'd101, 32'd101, 32'd101};
        chk_log("run3", e);

        // delta, then delta with wraparound
        step(1, ST_LIT, 32'd1000, 1);
        step(1, ST_DELTA, 32'h02FF0301, 1);
        drain();
        e = '{32'd1000, 32'd1001, 32'd1004, 32'd1003, 32'd1005};
        chk_log("delta", e);
        step(1, ST_LIT, 32'hFFFFFFFF, 1);
        step(1, ST_DELTA, 32'h00000001, 1);
        drain();
        e = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        chk_log("delta_wrap", e);

        // zero-length run emits nothing
        step(1, ST_LIT, 32'd7, 1);
        step(1, ST_RUN, 32'd0, 1);
        drain();
        e = '{32'd7};
        chk_log("run0", e);

        // run with no reference literal
        do_reset();
        step(1, ST_RUN, 32'd2, 1);
        drain();
        e = '{32'd0, 32'd0};
        chk_log("run_noref", e);
        chk("no_ref_set", {31'd0, no_ref}, 32'd1);

        // back-pressure and an enable gap in the middle of a run
        do_reset();
        step(1, ST_LIT, 32'd5, 1);
        step(1, ST_RUN, 32'd4, 1);
        step(1, ST_NONE, 32'd0, 0);
        step(1, ST_NONE, 32'd0, 0);
        step(1, ST_NONE, 32'd0, 1);
        step(1, ST_NONE, 32'd0, 0);
        step(0, ST_NONE, 32'd0, 1);
        step(1, ST_NONE, 32'd0, 0);
        step(1, ST_NONE, 32'd0, 1);
        drain();
        e = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
        chk_log("stall_run", e);

        // reset aborts a delta expansion
        step(1, ST_LIT, 32'd1000, 1);
        step(1, ST_DELTA, 32'h04030201, 1);
        step(1, ST_NONE, 32'd0, 1);
        do_reset();
        step(1, ST_LIT, 32'd9, 1);
        drain();
        e = '{32'd9};
        chk_log("post_reset", e);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                st = 2'($urandom_range(0, 3));
                r  = $urandom();
                if (st == ST_RUN) r = {r[31:16], 16'($urandom_range(0, 5))};
                step($urandom_range(0, 9) != 0, st, r, $urandom_range(0, 9) < 7);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
